// File: rtl/spu_instr_seq.sv
// spu_instr_seq: queues packed SPU instructions and issues them one at a time.
// For each issued instruction it pulses spu_config_en, then spu_start, waits
// for spu_end (with an optional timeout), then reports completion.
//
// Ports:
//   core_clk, rst_n      clock (rising edge) and async active-low reset
//   seq_en               issue enable (an instruction already in flight completes)
//   seq_abort            flush the queue and return to IDLE at the next edge
//   instr_valid/ready    push handshake; instr_data is the 128-bit packed instruction
//   timeout_limit        max WAIT cycles, 0 disables the timeout
//   err_clr              clears err_timeout / err_spurious (a set event wins)
//   spu_config_en/start  one-cycle control pulses to the SPU; spu_end is its completion pulse
//   *_out                fields of the instruction in flight, held until the next issue
//   busy, fifo_count, done_cnt, irq_done, err_timeout, err_spurious   status
//
// FIFO_DEPTH must be a power of two and at least 2 so that the pointers wrap
// naturally.
module spu_instr_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          core_clk,
  input  logic                          rst_n,
  input  logic                          seq_en,
  input  logic                          seq_abort,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [127:0]                  instr_data,
  input  logic [15:0]                   timeout_limit,
  input  logic                          err_clr,
  output logic                          spu_config_en,
  output logic                          spu_start,
  input  logic                          spu_end,
  output logic                          spu_op_out,
  output logic [ADDR_WIDTH-1:0]         spu_matrix_y_out,
  output logic [ADDR_WIDTH-1:0]         spu_matrix_x_out,
  output logic [3:0]                    shift0_out,
  output logic [3:0]                    shift1_out,
  output logic [4:0]                    shift2_out,
  output logic [ADDR_WIDTH-1:0]         im_base_addr_out,
  output logic [ADDR_WIDTH-1:0]         om_base_addr_out,
  output logic [ADDR_WIDTH-1:0]         im_block_align_out,
  output logic [ADDR_WIDTH-1:0]         om_block_align_out,
  output logic [6:0]                    ln_div_m_out,
  output logic [4:0]                    ln_div_e_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   done_cnt,
  output logic                          irq_done,
  output logic                          err_timeout,
  output logic                          err_spurious
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = 98;  // only bits [97:0] of an instruction carry fields

  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [IW-1:0]   cur_instr_r;
  logic [15:0]     wait_cnt_r;
  logic [15:0]     done_cnt_r;
  logic            config_en_r, start_r, busy_r, irq_r;
  logic            err_timeout_r, err_spurious_r;
  logic            push_s, pop_s, timeout_s, spurious_s;
  logic            unused_bits_s;

  assign unused_bits_s = ^instr_data[127:IW];

  assign instr_ready = (count_r != CNT_FULL) && !seq_abort;
  assign push_s      = instr_valid && instr_ready;
  assign timeout_s   = (state_r == WAIT) && !spu_end && (timeout_limit != 16'd0)
                       && (wait_cnt_r == (timeout_limit - 16'd1));
  assign spurious_s  = spu_end && (state_r != WAIT);

  // Next-state decode; an abort overrides everything, including the pop.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    if (seq_abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (seq_en && (count_r != CNT_ZERO)) begin
            state_nxt_s = CFG;
            pop_s       = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CFG:   state_nxt_s = START;
        START: state_nxt_s = WAIT;
        WAIT: begin
          // Completion beats a timeout landing in the same cycle.
          if (spu_end) begin
            state_nxt_s = DONE;
          end else if (timeout_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Control/status outputs registered from the next state so they line up with it.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      config_en_r <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      irq_r       <= 1'b0;
      done_cnt_r  <= 16'd0;
    end else begin
      config_en_r <= (state_nxt_s == CFG);
      start_r     <= (state_nxt_s == START);
      busy_r      <= (state_nxt_s != IDLE);
      irq_r       <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) begin
        done_cnt_r <= done_cnt_r + 16'd1;
      end else begin
        done_cnt_r <= done_cnt_r;
      end
    end
  end

  // Wait counter: zero outside WAIT, so it reads 0 in the first WAIT cycle.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == WAIT) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= 16'd0;
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clr wins.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_r  <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end else if (err_clr) begin
        err_timeout_r <= 1'b0;
      end else begin
        err_timeout_r <= err_timeout_r;
      end
      if (spurious_s) begin
        err_spurious_r <= 1'b1;
      end else if (err_clr) begin
        err_spurious_r <= 1'b0;
      end else begin
        err_spurious_r <= err_spurious_r;
      end
    end
  end

  // FIFO pointers and occupancy; abort flushes (push_s is already low then).
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else if (seq_abort) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge core_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= instr_data[IW-1:0];
    end
  end

  // Instruction in flight, captured on the IDLE->CFG pop and held until the next one.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_instr_r <= {IW{1'b0}};
    end else if (pop_s) begin
      cur_instr_r <= fifo_mem_r[rd_ptr_r];
    end else begin
      cur_instr_r <= cur_instr_r;
    end
  end

  assign spu_config_en      = config_en_r;
  assign spu_start          = start_r;
  assign busy               = busy_r;
  assign irq_done           = irq_r;
  assign done_cnt           = done_cnt_r;
  assign fifo_count         = count_r;
  assign err_timeout        = err_timeout_r;
  assign err_spurious       = err_spurious_r;

  assign spu_op_out         = cur_instr_r[0];
  assign spu_matrix_y_out   = ADDR_WIDTH'(cur_instr_r[12:1]);
  assign spu_matrix_x_out   = ADDR_WIDTH'(cur_instr_r[24:13]);
  assign shift0_out         = cur_instr_r[28:25];
  assign shift1_out         = cur_instr_r[32:29];
  assign shift2_out         = cur_instr_r[37:33];
  assign im_base_addr_out   = ADDR_WIDTH'(cur_instr_r[49:38]);
  assign om_base_addr_out   = ADDR_WIDTH'(cur_instr_r[61:50]);
  assign im_block_align_out = ADDR_WIDTH'(cur_instr_r[73:62]);
  assign om_block_align_out = ADDR_WIDTH'(cur_instr_r[85:74]);
  assign ln_div_m_out       = cur_instr_r[92:86];
  assign ln_div_e_out       = cur_instr_r[97:93];

endmodule

// File: tb/tb_spu_instr_seq.sv
// Directed testbench for spu_instr_seq: one task per scenario, inline checks.
module tb_spu_instr_seq;

  logic         core_clk, rst_n, seq_en, seq_abort, instr_valid, instr_ready;
  logic [127:0] instr_data;
  logic [15:0]  timeout_limit;
  logic         err_clr, spu_config_en, spu_start, spu_end, spu_op_out;
  logic [11:0]  spu_matrix_y_out, spu_matrix_x_out;
  logic [3:0]   shift0_out, shift1_out;
  logic [4:0]   shift2_out;
  logic [11:0]  im_base_addr_out, om_base_addr_out, im_block_align_out, om_block_align_out;
  logic [6:0]   ln_div_m_out;
  logic [4:0]   ln_div_e_out;
  logic         busy;
  logic [2:0]   fifo_count;
  logic [15:0]  done_cnt;
  logic         irq_done, err_timeout, err_spurious;

  int tests_run = 0;
  int tests_failed = 0;

  spu_instr_seq #(.ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .core_clk(core_clk), .rst_n(rst_n), .seq_en(seq_en), .seq_abort(seq_abort),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .timeout_limit(timeout_limit), .err_clr(err_clr),
    .spu_config_en(spu_config_en), .spu_start(spu_start), .spu_end(spu_end),
    .spu_op_out(spu_op_out), .spu_matrix_y_out(spu_matrix_y_out), .spu_matrix_x_out(spu_matrix_x_out),
    .shift0_out(shift0_out), .shift1_out(shift1_out), .shift2_out(shift2_out),
    .im_base_addr_out(im_base_addr_out), .om_base_addr_out(om_base_addr_out),
    .im_block_align_out(im_block_align_out), .om_block_align_out(om_block_align_out),
    .ln_div_m_out(ln_div_m_out), .ln_div_e_out(ln_div_e_out),
    .busy(busy), .fifo_count(fifo_count), .done_cnt(done_cnt), .irq_done(irq_done),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Pack an instruction; the ignored upper bits carry a junk pattern.
  function automatic logic [127:0] mk(input int op, input int y, input int x, input int s0,
                                      input int s1, input int s2, input int imb, input int omb,
                                      input int ima, input int oma, input int lm, input int le);
    logic [127:0] d;
    logic [29:0]  junk;
    junk        = 30'h2AAA_AAAA;
    d           = 128'd0;
    d[127:98]   = junk;
    d[0]        = op[0];
    d[12:1]     = y[11:0];
    d[24:13]    = x[11:0];
    d[28:25]    = s0[3:0];
    d[32:29]    = s1[3:0];
    d[37:33]    = s2[4:0];
    d[49:38]    = imb[11:0];
    d[61:50]    = omb[11:0];
    d[73:62]    = ima[11:0];
    d[85:74]    = oma[11:0];
    d[92:86]    = lm[6:0];
    d[97:93]    = le[4:0];
    return d;
  endfunction

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    instr_valid = 1'b1;
    instr_data  = d;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    tests_run++; if ({busy, spu_config_en, spu_start, irq_done, err_timeout, err_spurious} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 000000", {busy, spu_config_en, spu_start, irq_done, err_timeout, err_spurious}); end
    tests_run++; if ({fifo_count, done_cnt} !== 19'd0) begin tests_failed++; $display("FAIL reset_counts: got %0d/%0d want 0/0", fifo_count, done_cnt); end
    tests_run++; if ({spu_op_out, spu_matrix_y_out, im_base_addr_out, ln_div_e_out} !== 30'd0) begin
      tests_failed++; $display("FAIL reset_fields: got nonzero field outputs"); end
  endtask

  task automatic test_single_op();
    int bad;
    seq_en = 1'b0; timeout_limit = 16'd0;
    push(mk(1, 16, 64, 3, 5, 9, 'h0AB, 'h0CD, 'h010, 'h020, 77, 13));
    tests_run++; if (fifo_count !== 3'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    seq_en = 1'b1;
    tick();  // cycle 1
    tests_run++; if ({spu_config_en, spu_start} !== 2'b10) begin tests_failed++; $display("FAIL single_cfg: got %b want 10", {spu_config_en, spu_start}); end
    tests_run++; if ({spu_op_out, spu_matrix_y_out, spu_matrix_x_out} !== {1'b1, 12'd16, 12'd64}) begin
      tests_failed++; $display("FAIL single_fields: got op=%b y=%0d x=%0d want 1/16/64", spu_op_out, spu_matrix_y_out, spu_matrix_x_out); end
    tests_run++; if ({shift2_out, ln_div_m_out, om_block_align_out, fifo_count} !== {5'd9, 7'd77, 12'h020, 3'd0}) begin
      tests_failed++; $display("FAIL single_misc: got s2=%0d lm=%0d oma=%h cnt=%0d", shift2_out, ln_div_m_out, om_block_align_out, fifo_count); end
    tick();  // cycle 2
    tests_run++; if ({spu_config_en, spu_start} !== 2'b01) begin tests_failed++; $display("FAIL single_start: got %b want 01", {spu_config_en, spu_start}); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (irq_done || spu_start || spu_config_en || !busy) bad = 1;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL single_wait: got stray activity %0d want 0", bad); end
    spu_end = 1'b1;
    tick();
    spu_end = 1'b0;
    tests_run++; if ({irq_done, done_cnt} !== {1'b1, 16'd1}) begin tests_failed++; $display("FAIL single_done: got irq=%b cnt=%0d want 1/1", irq_done, done_cnt); end
    tick();
    tests_run++; if ({irq_done, busy, done_cnt} !== {2'b00, 16'd1}) begin tests_failed++; $display("FAIL single_idle: got irq=%b busy=%b cnt=%0d", irq_done, busy, done_cnt); end
    seq_en = 1'b0;
  endtask

  task automatic test_fifo_full();
    int accepted, idx, pend, last_start, cyc;
    seq_en = 1'b0; accepted = 0;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      instr_data  = mk(i, i + 1, 2 * i, i, 15 - i, 20 + i, 256 + i, 3840 - i, i, i, i, i);
      #1;
      if (instr_ready) accepted++;
      tick();
    end
    instr_valid = 1'b0;
    tests_run++; if (accepted !== 4) begin tests_failed++; $display("FAIL full_accept: got %0d want 4", accepted); end
    tests_run++; if ({fifo_count, instr_ready} !== {3'd4, 1'b0}) begin tests_failed++; $display("FAIL full_state: got cnt=%0d rdy=%b want 4/0", fifo_count, instr_ready); end
    seq_en = 1'b1; idx = 0; pend = 0; last_start = -1; cyc = 0;
    for (int c = 0; c < 80; c++) begin
      tick(); cyc++;
      spu_end = pend[0]; pend = 0;
      if (spu_start) begin
        pend = 1;
        if (last_start >= 0) begin
          tests_run++; if (cyc - last_start !== 5) begin tests_failed++; $display("FAIL b2b_spacing: got %0d want 5", cyc - last_start); end
        end
        last_start = cyc;
      end
      if (spu_config_en) begin
        tests_run++;
        if ({spu_op_out, spu_matrix_y_out, shift1_out, shift2_out, im_base_addr_out, om_base_addr_out} !==
            {idx[0], 12'(idx + 1), 4'(15 - idx), 5'(20 + idx), 12'(256 + idx), 12'(3840 - idx)}) begin
          tests_failed++;
          $display("FAIL order_%0d: got op=%b y=%0d imb=%h omb=%h", idx, spu_op_out, spu_matrix_y_out, im_base_addr_out, om_base_addr_out);
        end
        idx++;
      end
      if (idx == 4 && !busy) break;
    end
    spu_end = 1'b0; seq_en = 1'b0;
    tests_run++; if ({idx, busy} !== {32'd4, 1'b0}) begin tests_failed++; $display("FAIL full_issued: got %0d busy=%b want 4/0", idx, busy); end
    tests_run++; if (done_cnt !== 16'd5) begin tests_failed++; $display("FAIL full_donecnt: got %0d want 5", done_cnt); end
  endtask

  task automatic test_timeout();
    int found, n, early;
    timeout_limit = 16'd8; seq_en = 1'b0;
    push(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    seq_en = 1'b1; found = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (spu_start) begin found = 1; break; end end
    seq_en = 1'b0;
    tests_run++; if (found !== 1) begin tests_failed++; $display("FAIL tmo_start: got %0d want 1", found); end
    n = 0; early = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!busy) break;
      n++;
      if (err_timeout || irq_done) early = 1;
    end
    tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL tmo_cycles: got %0d want 8", n); end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL tmo_early: got %0d want 0", early); end
    tests_run++; if ({err_timeout, irq_done, done_cnt} !== {2'b10, 16'd5}) begin
      tests_failed++; $display("FAIL tmo_flag: got err=%b irq=%b cnt=%0d want 1/0/5", err_timeout, irq_done, done_cnt); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_clr: got %b want 0", err_timeout); end
    timeout_limit = 16'd0;
  endtask

  task automatic test_abort();
    int found, bad;
    seq_en = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(1, 100 + i, 5, 1, 1, 1, i, i, 0, 0, 0, 0));
    tests_run++; if (fifo_count !== 3'd3) begin tests_failed++; $display("FAIL abort_fill: got %0d want 3", fifo_count); end
    seq_en = 1'b1; found = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (spu_start) begin found = 1; break; end end
    tests_run++; if (found !== 1) begin tests_failed++; $display("FAIL abort_start: got %0d want 1", found); end
    tick(); tick();  // two cycles into WAIT
    seq_abort = 1'b1; instr_valid = 1'b1; instr_data = mk(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_ready: got %b want 0", instr_ready); end
    tick();
    seq_abort = 1'b0; instr_valid = 1'b0;
    tests_run++; if ({busy, fifo_count, spu_config_en, spu_start} !== 6'd0) begin
      tests_failed++; $display("FAIL abort_flush: got busy=%b cnt=%0d", busy, fifo_count); end
    bad = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (spu_start || spu_config_en || busy) bad = 1; end
    tests_run++; if ({bad[0], done_cnt} !== {1'b0, 16'd5}) begin tests_failed++; $display("FAIL abort_quiet: got bad=%0d cnt=%0d", bad, done_cnt); end
    seq_en = 1'b0;
  endtask

  task automatic test_spurious();
    int found;
    spu_end = 1'b1; tick(); spu_end = 1'b0;
    tests_run++; if ({err_spurious, busy, fifo_count} !== {2'b10, 3'd0}) begin
      tests_failed++; $display("FAIL spur_idle: got err=%b busy=%b cnt=%0d", err_spurious, busy, fifo_count); end
    spu_end = 1'b1; err_clr = 1'b1; tick(); spu_end = 1'b0; err_clr = 1'b0;
    tests_run++; if (err_spurious !== 1'b1) begin tests_failed++; $display("FAIL spur_setwins: got %b want 1", err_spurious); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tests_run++; if (err_spurious !== 1'b0) begin tests_failed++; $display("FAIL spur_clr: got %b want 0", err_spurious); end
    timeout_limit = 16'd4;
    push(mk(0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    seq_en = 1'b1; found = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (spu_start) begin found = 1; break; end end
    seq_en = 1'b0;
    tests_run++; if (found !== 1) begin tests_failed++; $display("FAIL coinc_start: got %0d want 1", found); end
    tick(); tick(); tick(); tick();  // WAIT cycle index 3 == limit-1
    tests_run++; if ({busy, irq_done} !== 2'b10) begin tests_failed++; $display("FAIL coinc_wait: got %b want 10", {busy, irq_done}); end
    spu_end = 1'b1; tick(); spu_end = 1'b0;
    tests_run++; if ({irq_done, err_timeout, err_spurious, done_cnt} !== {3'b100, 16'd6}) begin
      tests_failed++; $display("FAIL coinc_done: got irq=%b tmo=%b spur=%b cnt=%0d", irq_done, err_timeout, err_spurious, done_cnt); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL coinc_idle: got %b want 0", busy); end
    timeout_limit = 16'd0;
  endtask

  task automatic test_reset_mid_wait();
    int found;
    seq_en = 1'b0;
    push(mk(1, 9, 9, 1, 1, 1, 1, 1, 1, 1, 1, 1));
    push(mk(1, 8, 8, 2, 2, 2, 2, 2, 2, 2, 2, 2));
    spu_end = 1'b1; tick(); spu_end = 1'b0;  // leave err_spurious set
    seq_en = 1'b1; found = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (spu_start) begin found = 1; break; end end
    seq_en = 1'b0;
    tests_run++; if ({found[0], err_spurious} !== 2'b11) begin tests_failed++; $display("FAIL rst_setup: got %0d/%b want 1/1", found, err_spurious); end
    tick();  // in WAIT
    #3; rst_n = 1'b0; #1;
    tests_run++; if ({busy, spu_config_en, spu_start, irq_done, err_timeout, err_spurious} !== 6'b0) begin
      tests_failed++; $display("FAIL rst_ctrl: got %b want 000000", {busy, spu_config_en, spu_start, irq_done, err_timeout, err_spurious}); end
    tests_run++; if ({fifo_count, done_cnt, spu_op_out, spu_matrix_y_out, om_base_addr_out, shift0_out} !== 48'd0) begin
      tests_failed++; $display("FAIL rst_state: got cnt=%0d done=%0d y=%0d", fifo_count, done_cnt, spu_matrix_y_out); end
    #2; rst_n = 1'b1; #1;
    tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
    tick();
    tests_run++; if ({busy, fifo_count} !== 4'd0) begin tests_failed++; $display("FAIL rst_after: got busy=%b cnt=%0d", busy, fifo_count); end
  endtask

  initial begin
    rst_n = 1'b0; seq_en = 1'b0; seq_abort = 1'b0; instr_valid = 1'b0; instr_data = 128'd0;
    timeout_limit = 16'd0; err_clr = 1'b0; spu_end = 1'b0;
    repeat (2) @(posedge core_clk);
    #3; rst_n = 1'b1; #1;
    test_reset();
    tick();
    test_single_op();
    test_fifo_full();
    test_timeout();
    test_abort();
    test_spurious();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spu_instr_seq.md
SPU_INSTR_SEQ -- requirements
Module: spu_instr_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, the width of every address/dimension field driven to the SPU.
REQ-002 Parameter FIFO_DEPTH, default 4, the instruction queue depth; it SHALL be a power of 2 and at least 2.
REQ-003 core_clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seq_en  input  1  issue enable; while low, no new instruction is issued.
REQ-006 seq_abort  input  1  abort-and-flush request.
REQ-007 instr_valid / instr_ready  input / output  1 / 1  push handshake.
REQ-008 instr_data  input  128  packed instruction, bit fields as follows:
- [0] op
- [12:1] matrix_y; [24:13] matrix_x
- [28:25] shift0; [32:29] shift1; [37:33] shift2
- [49:38] im_base; [61:50] om_base
- [73:62] im_align; [85:74] om_align
- [92:86] ln_div_m; [97:93] ln_div_e
- [127:98] ignored
REQ-009 timeout_limit  input  16  maximum number of WAIT cycles; a value of 0 disables the timeout.
REQ-010 err_clr  input  1  clears the sticky error flags.
REQ-011 spu_config_en, spu_start  output  1 each  control to the SPU.
REQ-012 spu_end  input  1  completion pulse from the SPU.
REQ-013 Outputs to the SPU, with widths:
- spu_op_out (1)
- spu_matrix_y_out, spu_matrix_x_out (ADDR_WIDTH)
- shift0_out, shift1_out (4); shift2_out (5)
- im_base_addr_out, om_base_addr_out, im_block_align_out, om_block_align_out (ADDR_WIDTH)
- ln_div_m_out (7); ln_div_e_out (5)
REQ-014 Status outputs:
- busy (1)
- fifo_count (clog2(FIFO_DEPTH)+1)
- done_cnt (16)
- irq_done (1)
- err_timeout (1), err_spurious (1)

Function
REQ-015 instr_ready SHALL equal (fifo_count != FIFO_DEPTH) && !seq_abort; a push occurs when instr_valid && instr_ready.
REQ-016 The FIFO SHALL be first-in first-out with wrapping pointers; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-017 The FSM states SHALL be IDLE, CFG, START, WAIT and DONE.
REQ-018 IDLE -> CFG when seq_en is high and fifo_count > 0; on that edge the head entry is popped and its fields are registered onto the field outputs.
REQ-019 In CFG, spu_config_en SHALL be 1 for exactly one cycle; next state is START.
REQ-020 In START, spu_start SHALL be 1 for exactly one cycle; next state is WAIT.
REQ-021 The field outputs SHALL hold the popped values from CFG until the next CFG.
REQ-022 WAIT -> DONE on spu_end.
REQ-023 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-024 If timeout_limit != 0 and the wait counter equals timeout_limit - 1 without spu_end:
- err_timeout is set;
- the FSM goes WAIT -> IDLE;
- done_cnt is not incremented.
REQ-025 spu_end takes priority over a timeout in the same cycle.
REQ-026 In DONE, irq_done SHALL be 1 for one cycle and done_cnt SHALL increment (wrapping at 16 bits); next state is IDLE.
REQ-027 spu_end in any state other than WAIT SHALL set err_spurious and cause no state change.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Once CFG has been entered, the instruction in flight SHALL complete even if seq_en drops.
REQ-030 On seq_abort, at the next edge, from any state:
- the FSM goes to IDLE;
- the FIFO is flushed (pointers and count = 0);
- spu_config_en and spu_start are 0;
- any push in that cycle is dropped.
REQ-031 err_clr SHALL clear both error flags; a set event in the same cycle wins over the clear.
REQ-032 Back-to-back issue: DONE -> IDLE -> CFG, so the minimum spacing between successive spu_start pulses is (WAIT cycles + 4).

Reset
REQ-033 Asynchronous assertion of rst_n SHALL force all of the following, regardless of the state:
- FSM = IDLE;
- FIFO empty;
- all field outputs = 0;
- spu_config_en = spu_start = 0;
- busy = irq_done = 0;
- done_cnt = 0;
- both error flags = 0.
REQ-034 After reset release, instr_ready SHALL be 1 in the first cycle.

Verification
REQ-035 Single op: push an instruction with op=1, y=16, x=64, seq_en=1, SPU model ends 20 cycles after start -> config_en at cycle 1, start at cycle 2, irq_done once, done_cnt=1, y_out=16, x_out=64.
REQ-036 FIFO full: push 5 instructions with seq_en=0 -> 4 accepted, instr_ready=0, fifo_count=4; raise seq_en -> instructions issued in push order; op/base fields match each push.
REQ-037 Timeout: timeout_limit=8, no spu_end -> err_timeout=1 after 8 WAIT cycles, FSM IDLE, done_cnt unchanged; err_clr -> err_timeout=0.
REQ-038 Abort: 3 queued instructions, abort during WAIT -> next cycle busy=0, fifo_count=0, no further spu_start.
REQ-039 Spurious end: spu_end pulsed in IDLE -> err_spurious=1, no state change; spu_end coincident with timeout -> DONE, no err_timeout.
REQ-040 Reset mid-WAIT: assert rst_n low -> all outputs 0 immediately, FIFO empty.
